// File: rtl/imem_loader.sv
// Byte-stream loader: assembles big-endian words from a host byte link and writes them to imem.
// Optional trailing XOR checksum byte is enabled with `define LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDRESS_WIDTH = 12,
  parameter int DEPTH         = 4096
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  output logic                     rx_ready,
  input  logic                     load_start,
  output logic                     imem_wEn,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  output logic [31:0]              imem_dataIn,
  output logic                     cpu_reset,
  output logic                     done,
  output logic                     error
);

  typedef enum logic [2:0] {
    S_CNT_HI,
    S_CNT_LO,
    S_DATA,
    S_WRITE,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  // Where a load goes once every word has been written (or count was zero).
`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_FIN = S_CSUM;
`else
  localparam state_t S_FIN = S_DONE;
`endif

  state_t                 state, state_n;
  logic [15:0]            count;
  logic [ADDRESS_WIDTH:0] widx;
  logic [ADDRESS_WIDTH:0] widx_nxt;
  logic [1:0]             bidx;
  logic [31:0]            word;
  logic [15:0]            cnt_in;
  logic                   xfer;
  logic                   restart;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]             csum;
`endif

  assign xfer     = rx_valid & rx_ready;
  assign cnt_in   = {count[15:8], rx_data};
  assign widx_nxt = widx + 1'b1;
  assign restart  = load_start & ((state == S_DONE) | (state == S_ERROR));

  always_ff @(posedge clock) begin
    if (!reset) state <= S_CNT_HI;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    rx_ready  = 1'b0;
    imem_wEn  = 1'b0;
    cpu_reset = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    case (state)
      S_CNT_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) state_n = S_CNT_LO;
      end
      S_CNT_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (cnt_in == 16'd0)                   state_n = S_FIN;
          else if (32'(cnt_in) > 32'(DEPTH))     state_n = S_ERROR;
          else                                   state_n = S_DATA;
        end
      end
      S_DATA: begin
        rx_ready = 1'b1;
        if (rx_valid && bidx == 2'd3) state_n = S_WRITE;
      end
      S_WRITE: begin
        imem_wEn = 1'b1;
        state_n  = (32'(widx_nxt) == 32'(count)) ? S_FIN : S_DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        rx_ready = 1'b1;
        if (rx_valid) state_n = (rx_data == csum) ? S_DONE : S_ERROR;
      end
`endif
      S_DONE: begin
        done      = 1'b1;
        cpu_reset = 1'b0;
        if (load_start) state_n = S_CNT_HI;
      end
      S_ERROR: begin
        error = 1'b1;
        if (load_start) state_n = S_CNT_HI;
      end
      default: state_n = S_CNT_HI;
    endcase
  end

  // Address/data are latched with the 4th byte so they are valid throughout WRITE and hold afterwards.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count       <= '0;
      widx        <= '0;
      bidx        <= '0;
      word        <= '0;
      imem_addr   <= '0;
      imem_dataIn <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      if (restart) begin
        widx <= '0;
        bidx <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum <= '0;
`endif
      end
      if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
        csum <= csum ^ rx_data;
`endif
        case (state)
          S_CNT_HI: count[15:8] <= rx_data;
          S_CNT_LO: count[7:0]  <= rx_data;
          S_DATA: begin
            word <= {word[23:0], rx_data};
            bidx <= bidx + 2'd1;
            if (bidx == 2'd3) begin
              imem_addr   <= widx[ADDRESS_WIDTH-1:0];
              imem_dataIn <= {word[23:0], rx_data};
            end
          end
          default: ;
        endcase
      end
      if (state == S_WRITE) widx <= widx_nxt;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as words are sent and
// popped by a monitor on every imem_wEn pulse.
module tb_imem_loader;
  localparam int AW    = 12;
  localparam int DEPTH = 4096;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready;
  logic          load_start = 1'b0;
  logic          imem_wEn;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_dataIn;
  logic          cpu_reset, done, error;

  imem_loader #(.ADDRESS_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .load_start(load_start), .imem_wEn(imem_wEn), .imem_addr(imem_addr), .imem_dataIn(imem_dataIn),
    .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  int          errors = 0;
  int          checks = 0;
  wr_t         exp_q[$];
  wr_t         mon_e;
  int          wen_cnt = 0;
  logic        prev_wen = 1'b0;
  logic        gaps = 1'b0;
  logic [7:0]  tx_csum = 8'h00;
  logic [31:0] tx_words[$];
  int          base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (imem_wEn === 1'b1) begin
      wen_cnt++;
      check("wen_single_cycle", 32'(prev_wen), 32'd0);
      check("ready_low_in_write", 32'(rx_ready), 32'd0);
      check("write_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(imem_addr), 32'(mon_e.addr));
        check("wr_data", imem_dataIn, mon_e.data);
      end
    end
    prev_wen = imem_wEn;
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clock);
    @(negedge clock);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!rx_ready) begin
      check("rx_ready_timeout", 32'(rx_ready), 32'd1);
      rx_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1 rx_valid = 1'b0;
    tx_csum = tx_csum ^ b;
  endtask

  // 4th byte accepted at t must show the write strobe in the very next cycle.
  task automatic send_word(input logic [31:0] w, input int addr);
    exp_q.push_back(wr_t'{AW'(addr), w});
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
    @(negedge clock);
    check("wen_latency", 32'(imem_wEn), 32'd1);
  endtask

  task automatic send_frame();
    int n = tx_words.size();
    logic [7:0] c;
    tx_csum = 8'h00;
    send_byte(8'(n >> 8));
    send_byte(8'(n));
    for (int i = 0; i < n; i++) send_word(tx_words[i], i);
`ifdef LOADER_CHECKSUM_EN
    c = tx_csum;
    send_byte(c);
`else
    c = 8'h00;
`endif
  endtask

  task automatic wait_end(input string tag, input logic exp_done);
    int n = 0;
    while (!(done || error) && n < 20) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_done"},      32'(done),      32'(exp_done));
    check({tag, "_error"},     32'(error),     32'(!exp_done));
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(!exp_done));
    check({tag, "_rx_ready"},  32'(rx_ready),  32'd0);
  endtask

  task automatic pulse_start(input string tag);
    @(negedge clock);
    load_start = 1'b1;
    @(negedge clock);
    load_start = 1'b0;
    check({tag, "_restart_ctrl"}, 32'({rx_ready, cpu_reset, done, error}), 32'b1100);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ctrl"}, 32'({rx_ready, imem_wEn, cpu_reset, done, error}), 32'b10100);
    check({tag, "_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_data"}, imem_dataIn, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_reset_state("reset");
    reset = 1'b1;

    // Two-word load
    tx_words = '{32'hDEADBEEF, 32'h00000013};
    send_frame();
    wait_end("t1", 1'b1);
    check("t1_wen_count", 32'(wen_cnt), 32'd2);
    check("t1_addr_hold", 32'(imem_addr), 32'd1);
    check("t1_data_hold", imem_dataIn, 32'h00000013);

    // Zero-length load completes without writes
    pulse_start("t2");
    base = wen_cnt;
    tx_words.delete();
    send_frame();
    wait_end("t2", 1'b1);
    check("t2_no_write", 32'(wen_cnt - base), 32'd0);

    // Count above DEPTH
    pulse_start("t3a");
    base = wen_cnt;
    tx_csum = 8'h00;
    send_byte(8'h10);
    send_byte(8'h01);
    wait_end("t3", 1'b0);
    check("t3_no_write", 32'(wen_cnt - base), 32'd0);
    pulse_start("t3b");

    // Random gaps; a load_start mid-frame must be ignored
    gaps = 1'b1;
    base = wen_cnt;
    tx_csum = 8'h00;
    send_byte(8'h00);
    send_byte(8'h03);
    send_word($urandom(), 0);
    @(negedge clock);
    load_start = 1'b1;
    @(negedge clock);
    load_start = 1'b0;
    send_word($urandom(), 1);
    send_word($urandom(), 2);
`ifdef LOADER_CHECKSUM_EN
    send_byte(tx_csum);
`endif
    wait_end("t4", 1'b1);
    check("t4_wen_count", 32'(wen_cnt - base), 32'd3);
    gaps = 1'b0;

    // Reset in the middle of word 1
    pulse_start("t5a");
    base = wen_cnt;
    tx_csum = 8'h00;
    send_byte(8'h00);
    send_byte(8'h02);
    send_word(32'hA5A50001, 0);
    send_byte(8'h12);
    send_byte(8'h34);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_reset_state("t5_reset");
    reset = 1'b1;
    check("t5_no_partial", 32'(wen_cnt - base), 32'd1);
    tx_words = '{32'hCAFEF00D};
    send_frame();
    wait_end("t5", 1'b1);
    check("t5_wen_count", 32'(wen_cnt - base), 32'd2);

`ifdef LOADER_CHECKSUM_EN
    // Checksum: XOR over every byte including the count bytes
    pulse_start("t6a");
    tx_words = '{32'h11223344};
    send_frame();
    wait_end("t6_good", 1'b1);
    pulse_start("t6b");
    base = wen_cnt;
    tx_csum = 8'h00;
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(32'h11223344, 0);
    send_byte(tx_csum ^ 8'h01);
    wait_end("t6_bad", 1'b0);
    check("t6_bad_written", 32'(wen_cnt - base), 32'd1);
`endif

    repeat (3) @(negedge clock);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
